// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: op encodings, FSM states
// and default operand geometry.
package shift_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_LEVELS = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    SRA  = 2'b10,
    ROTR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_stage.sv
// Single shared shift level: moves acc by 2^lvl positions with the fill
// appropriate to the operation. Purely combinational.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEVELS = $clog2(WIDTH),
  parameter int LVL_W  = $clog2(LEVELS)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [LVL_W-1:0] lvl,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = acc;
    // Each level is a fixed-distance shift; lvl just picks which one is used.
    for (int k = 0; k < LEVELS; k++) begin
      if (lvl == LVL_W'(k)) begin
        case (shift_op_e'(op))
          SLL:     shifted = acc << (1 << k);
          SRL:     shifted = acc >> (1 << k);
          SRA:     shifted = (acc >> (1 << k)) |
                             ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> (1 << k)));
          default: shifted = (acc >> (1 << k)) | (acc << (WIDTH - (1 << k)));
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one logarithmic level per clock through shift_stage,
// fixed latency with a start/done handshake.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [LEVELS-1:0] shamt,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [1:0]        dbg_state
);

  localparam int LVL_W = $clog2(LEVELS);

  // Handshake: start is sampled only in IDLE; done pulses for exactly one
  // cycle when result updates; busy is high for every SHIFT cycle.
  shift_state_e      state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [1:0]        op_q, op_d;
  logic [LEVELS-1:0] shamt_q, shamt_d;
  logic              sign_q, sign_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  stage_out;

  shift_stage #(
    .WIDTH (WIDTH),
    .LEVELS(LEVELS),
    .LVL_W (LVL_W)
  ) u_stage (
    .acc    (acc_q),
    .op     (op_q),
    .sign   (sign_q),
    .lvl    (lvl_q),
    .shifted(stage_out)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    op_d     = op_q;
    shamt_d  = shamt_q;
    sign_d   = sign_q;
    lvl_d    = lvl_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = data_in;
          op_d    = op;
          shamt_d = shamt;
          sign_d  = data_in[WIDTH-1];
          lvl_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (shamt_q[lvl_q]) acc_d = stage_out;
        lvl_d = lvl_q + 1'b1;
        if (lvl_q == LVL_W'(LEVELS - 1)) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_d;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      op_q     <= '0;
      shamt_q  <= '0;
      sign_q   <= 1'b0;
      lvl_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      sign_q   <= sign_d;
      lvl_q    <= lvl_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and swept checks of shift_sequencer results, handshake timing,
// start suppression and mid-operation reset.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  shift_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] s);
    case (o)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return $unsigned($signed(d) >>> s);
      default: return (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
    endcase
  endfunction

  // driver: start held for exactly one edge (E0)
  task automatic drive_start(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    data_in = d;
    shamt   = s;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cycles 1..5 busy, cycle 6 done with result
  task automatic expect_op(input string tag, input logic [31:0] exp);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_val($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      check_val($sformatf("%s done c%0d", tag, c), 32'(done), 32'd0);
    end
    @(negedge clk);
    check_val({tag, " done c6"}, 32'(done), 32'd1);
    check_val({tag, " busy c6"}, 32'(busy), 32'd0);
    check_val({tag, " result"}, result, exp);
  endtask

  initial begin
    int done_seen;
    int waited;
    logic [1:0]  ro;
    logic [31:0] rd;
    logic [4:0]  rs;

    rst = 1'b1; start = 1'b0; op = 2'd0; data_in = '0; shamt = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("reset busy", 32'(busy), 32'd0);
    check_val("reset done", 32'(done), 32'd0);
    check_val("reset result", result, 32'h0);
    check_val("reset state", 32'(dbg_state), 32'(IDLE));

    // release reset with start already high: accepted on first edge
    start = 1'b1; op = SLL; data_in = 32'h0000_0001; shamt = 5'd31;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    expect_op("sll1x31", 32'h8000_0000);

    drive_start(SRA, 32'h8000_0000, 5'd4);
    expect_op("sra", 32'hF800_0000);
    drive_start(SRL, 32'h8000_0000, 5'd4);
    expect_op("srl", 32'h0800_0000);
    drive_start(ROTR, 32'h0000_0001, 5'd1);
    expect_op("rotr1", 32'h8000_0000);
    drive_start(ROTR, 32'h1234_5678, 5'd16);
    expect_op("rotr16", 32'h5678_1234);
    drive_start(SRA, 32'hDEAD_BEEF, 5'd0);
    expect_op("sra0", 32'hDEAD_BEEF);
    drive_start(ROTR, 32'hA5A5_0F0F, 5'd0);
    expect_op("rotr0", 32'hA5A5_0F0F);
    drive_start(SLL, 32'h0000_00FF, 5'd0);
    expect_op("sll0", 32'h0000_00FF);

    // starts during SHIFT/DONE and operand changes are ignored
    drive_start(SRL, 32'hF0F0_F0F0, 5'd4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 5) check_val($sformatf("ign busy c%0d", c), 32'(busy), 32'd1);
      if (c == 6) begin
        check_val("ign done c6", 32'(done), 32'd1);
        check_val("ign result", result, 32'h0F0F_0F0F);
      end
      if (c == 1) begin op = SLL; data_in = 32'hFFFF_FFFF; shamt = 5'd0; end
      if (c == 2) start = 1'b1;
      if (c == 3) start = 1'b0;
      if (c == 6) begin start = 1'b1; op = ROTR; data_in = 32'h1234_5678; shamt = 5'd16; end
    end
    @(negedge clk);
    check_val("ign c7 busy", 32'(busy), 32'd0);
    check_val("ign c7 done", 32'(done), 32'd0);
    check_val("ign c7 result", result, 32'h0F0F_0F0F);
    @(negedge clk);
    check_val("c7 accept busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      check_val($sformatf("c7op busy c%0d", c), 32'(busy), 32'd1);
    end
    @(negedge clk);
    check_val("c7op done", 32'(done), 32'd1);
    check_val("c7op result", result, 32'h5678_1234);

    // reset in cycle 3 of an operation
    drive_start(SLL, 32'h0000_00FF, 5'd8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst done", 32'(done), 32'd0);
    check_val("rst result", result, 32'h0);
    check_val("rst state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_val("rst no done", 32'(done_seen), 32'd0);
    drive_start(SRA, 32'h4000_0000, 5'd30);
    expect_op("post rst", 32'h0000_0001);

    // random sweep against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 31));
      rd = $urandom;
      exp_q.push_back(ref_shift(ro, rd, rs));
      drive_start(ro, rd, rs);
      waited = 0;
      while (!done && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      if (!done) begin
        check_val($sformatf("sweep %0d timeout", i), 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end else begin
        check_val($sformatf("sweep %0d op%0d s%0d d%08h", i, ro, rs, rd), result, exp_q.pop_front());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
